// File: rtl/operand_bypass_unit.sv
// operand_bypass_unit: ALU-stage operand forwarding for the 5-stage MIPS pipeline.
// Picks the Rs/Rt operands from the previous-cycle ALU result (H1), then the
// writeback result (H2), then the register-file read data.
// Optional feature macro: BYPASS_WB_FORWARD_EN. When it is defined, the
// writeback history entry H2 exists. When it is undefined, only H1 is kept,
// and the register file must be write-first.
module operand_bypass_unit #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rs_index,
    input  logic [IDX_W-1:0]  rt_index,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic [IDX_W-1:0]  rd_index,
    input  logic [DATA_W-1:0] rd_value,
    input  logic              rd_we,
    output logic [DATA_W-1:0] bypassed_rs_val,
    output logic [DATA_W-1:0] bypassed_rt_val
);

    // H1: result the ALU produced last cycle
    logic              vld_p1;
    logic [IDX_W-1:0]  idx_p1;
    logic [DATA_W-1:0] val_p1;

`ifdef BYPASS_WB_FORWARD_EN
    // H2: result now in writeback
    logic              vld_p2;
    logic [IDX_W-1:0]  idx_p2;
    logic [DATA_W-1:0] val_p2;
`endif

    // Youngest matching history entry wins. Index 0 can never match, because
    // zero-register writes are never captured as valid.
    function automatic logic [DATA_W-1:0] select_operand(
        input logic [IDX_W-1:0]  q_idx,
        input logic [DATA_W-1:0] reg_val
    );
        logic [DATA_W-1:0] r;
        r = reg_val;
`ifdef BYPASS_WB_FORWARD_EN
        if (vld_p2 && (idx_p2 == q_idx)) r = val_p2;
`endif
        if (vld_p1 && (idx_p1 == q_idx)) r = val_p1;
        return r;
    endfunction

    // Capture the valid bit of the ALU result; reset clears it
    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= rd_we && (rd_index != '0);
    end

    // Capture the index and data of the ALU result; these need no reset because valid gates them
    always_ff @(posedge clk) begin
        idx_p1 <= rd_index;
        val_p1 <= rd_value;
    end

`ifdef BYPASS_WB_FORWARD_EN
    // Age the H1 valid bit into H2; reset clears it
    always_ff @(posedge clk) begin
        if (rst) vld_p2 <= 1'b0;
        else     vld_p2 <= vld_p1;
    end

    // Age the H1 index and data into H2
    always_ff @(posedge clk) begin
        idx_p2 <= idx_p1;
        val_p2 <= val_p1;
    end
`endif

    // Operand selection, driven only by the stored history and the operand inputs
    always_comb begin
        bypassed_rs_val = select_operand(rs_index, rs_val);
        bypassed_rt_val = select_operand(rt_index, rt_val);
    end

endmodule

// File: tb/tb_operand_bypass_unit.sv
// Testbench for operand_bypass_unit: directed literal cases plus randomized
// traffic checked against a cycle-history reference model.
module tb_operand_bypass_unit;

    localparam int DATA_W = 32;
    localparam int IDX_W  = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [IDX_W-1:0]  rs_index = '0;
    logic [IDX_W-1:0]  rt_index = '0;
    logic [DATA_W-1:0] rs_val = '0;
    logic [DATA_W-1:0] rt_val = '0;
    logic [IDX_W-1:0]  rd_index = '0;
    logic [DATA_W-1:0] rd_value = '0;
    logic              rd_we = 1'b0;
    logic [DATA_W-1:0] bypassed_rs_val;
    logic [DATA_W-1:0] bypassed_rt_val;

    int total = 0;
    int bad   = 0;

    operand_bypass_unit #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .rs_index        (rs_index),
        .rt_index        (rt_index),
        .rs_val          (rs_val),
        .rt_val          (rt_val),
        .rd_index        (rd_index),
        .rd_value        (rd_value),
        .rd_we           (rd_we),
        .bypassed_rs_val (bypassed_rs_val),
        .bypassed_rt_val (bypassed_rt_val)
    );

    always #5 clk = ~clk;

    // One record per past clock edge: what was presented and whether reset was high
    typedef struct {
        bit                rst;
        bit                we;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] val;
    } rec_t;

    rec_t hist[$];   // hist[0] = last cycle, hist[1] = two cycles ago

`ifdef BYPASS_WB_FORWARD_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    // A write made k cycles ago is visible if it was enabled, targeted a
    // nonzero register, and no reset edge happened since (including its own).
    function automatic logic [DATA_W-1:0] model(input logic [IDX_W-1:0] q,
                                                input logic [DATA_W-1:0] regval);
        logic [DATA_W-1:0] r;
        bit killed;
        r = regval;
        killed = 1'b0;
        if (q != 0) begin
            for (int k = 0; k < DEPTH && k < hist.size(); k++) begin
                killed = killed | hist[k].rst;
                if (!killed && hist[k].we && hist[k].idx == q) begin
                    r = hist[k].val;
                    break;
                end
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Compare both outputs against the model mid-cycle, then log this cycle's write
    always @(negedge clk) begin
        check("model_rs", bypassed_rs_val, model(rs_index, rs_val));
        check("model_rt", bypassed_rt_val, model(rt_index, rt_val));
        hist.push_front('{rst: rst, we: rd_we, idx: rd_index, val: rd_value});
        if (hist.size() > 2) void'(hist.pop_back());
    end

    task automatic step(input bit r, input bit we, input int wi, input logic [31:0] wv,
                        input int si, input logic [31:0] sv,
                        input int ti, input logic [31:0] tv);
        @(posedge clk);
        #1;
        rst = r; rd_we = we; rd_index = IDX_W'(wi); rd_value = wv;
        rs_index = IDX_W'(si); rs_val = sv; rt_index = IDX_W'(ti); rt_val = tv;
        #1;
    endtask

    initial begin
        // Reset, then idle; a write presented during reset must not be captured
        rst = 1'b1; rs_index = 5'd3; rt_index = 5'd3; rs_val = 32'h11; rt_val = 32'h22;
        step(1, 0, 0, 0, 3, 32'h11, 3, 32'h22);
        check("rst_rs", bypassed_rs_val, 32'h11);
        check("rst_rt", bypassed_rt_val, 32'h22);
        step(1, 1, 3, 32'h55, 3, 32'h11, 3, 32'h22);
        check("rst_wr_rs", bypassed_rs_val, 32'h11);
        step(0, 0, 0, 0, 3, 32'h11, 3, 32'h22);
        check("post_rst_rs", bypassed_rs_val, 32'h11);
        check("post_rst_rt", bypassed_rt_val, 32'h22);
        step(0, 0, 0, 0, 3, 32'h11, 3, 32'h22);
        check("post_rst2_rs", bypassed_rs_val, 32'h11);

        // Distance-1 forward
        step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        step(0, 0, 0, 0, 5, 32'h0, 6, 32'h7);
        check("d1_rs", bypassed_rs_val, 32'hDEADBEEF);
        check("d1_rt", bypassed_rt_val, 32'h7);

        // Distance-2 forward
        step(0, 1, 7, 32'hA5A5A5A5, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 7, 32'h1);
`ifdef BYPASS_WB_FORWARD_EN
        check("d2_rt", bypassed_rt_val, 32'hA5A5A5A5);
`else
        check("d2_rt", bypassed_rt_val, 32'h1);
`endif

        // Priority: the younger write wins
        step(0, 1, 9, 32'h100, 0, 0, 0, 0);
        step(0, 1, 9, 32'h200, 0, 0, 0, 0);
        step(0, 0, 0, 0, 9, 32'h5, 0, 0);
        check("prio_h1", bypassed_rs_val, 32'h200);
        step(0, 0, 0, 0, 9, 32'h5, 0, 0);
`ifdef BYPASS_WB_FORWARD_EN
        check("prio_h2", bypassed_rs_val, 32'h200);
`else
        check("prio_h2", bypassed_rs_val, 32'h5);
`endif

        // Zero register and write-disable
        step(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
        step(0, 0, 4, 32'h99, 0, 32'h0, 0, 32'h0);
        check("zero_rs", bypassed_rs_val, 32'h0);
        check("zero_rt", bypassed_rt_val, 32'h0);
        step(0, 0, 0, 0, 4, 32'h3, 0, 0);
        check("we0_rs", bypassed_rs_val, 32'h3);

        // Both operands read the same forwarded register
        step(0, 1, 12, 32'h1234, 0, 0, 0, 0);
        step(0, 0, 0, 0, 12, 32'hAAAA, 12, 32'hBBBB);
        check("same_rs", bypassed_rs_val, 32'h1234);
        check("same_rt", bypassed_rt_val, 32'h1234);

        // A reset in mid-stream kills a write that was just captured
        step(0, 1, 2, 32'hCAFE, 0, 0, 0, 0);
        step(1, 0, 0, 0, 2, 32'h8, 0, 0);
        check("midrst_pre", bypassed_rs_val, 32'hCAFE);
        step(0, 0, 0, 0, 2, 32'h8, 0, 0);
        check("midrst_post", bypassed_rs_val, 32'h8);

        // Randomized traffic: narrow index range for frequent hazards
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 70),
                 int'($urandom_range(0, 7)), $urandom,
                 int'($urandom_range(0, 7)), $urandom,
                 int'($urandom_range(0, 7)), $urandom);
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_bypass_unit.md
Name: operand_bypass_unit

Overview:
- ALU-stage operand forwarding network for the 5-stage MIPS pipeline.
- Selects the Rs/Rt operand values the ALU consumes this cycle.
- Sources, in priority order: the result produced by the ALU in the previous cycle, then the result now in writeback, then the register-file read data.
- Sits between regfetch (synchronous regfile read) and the ALU stage.

Parameters:
- DATA_W, 32, operand/result width.
- IDX_W, 5, register index width; index 0 is the hard-wired zero register.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- rs_index  input  IDX_W  Rs index of the instruction currently in ALU stage.
- rt_index  input  IDX_W  Rt index of the instruction currently in ALU stage.
- rs_val  input  DATA_W  register-file read data for rs_index.
- rt_val  input  DATA_W  register-file read data for rt_index.
- rd_index  input  IDX_W  destination index produced by the ALU this cycle.
- rd_value  input  DATA_W  result value produced by the ALU this cycle.
- rd_we  input  1  ALU-stage register-write enable for rd_index/rd_value.
- bypassed_rs_val  output  DATA_W  forwarded Rs operand (combinational).
- bypassed_rt_val  output  DATA_W  forwarded Rt operand (combinational).

Behaviour:
- State: two history entries, H1 and H2, each holding {valid, idx, val}.
- Every posedge clk, not in reset:
  - H1.valid <= rd_we && (rd_index != 0); H1.idx <= rd_index; H1.val <= rd_value.
  - H2 <= H1 (whole entry).
- Reset (rst=1 at posedge): H1.valid and H2.valid <= 0; idx/val contents are don't-care.
- Reset asserted mid-stream: forwarding is suppressed from the cycle after the reset edge until new writes are captured.
- Output select for Rs (Rt is identical, using rt_index/rt_val):
  - H1.valid && H1.idx == rs_index -> H1.val.
  - else H2.valid && H2.idx == rs_index -> H2.val.
  - else rs_val.
- Priority on simultaneous matches: H1 (youngest) wins over H2.
- rs_index == 0: always yields rs_val. Zero-register writes are never captured as valid, so they are never forwarded.
- Outputs depend combinationally only on the index/value inputs and the stored history. There is no combinational path from rd_index/rd_value/rd_we to the outputs, which avoids the ALU feedback loop.
- Latency: a result presented on rd_* in cycle t is forwardable in cycles t+1 (via H1) and t+2 (via H2).
- Values are forwarded verbatim with no width or sign manipulation.
- The producer is responsible for deasserting rd_we, or stalling, when rd_value is not the final register value (e.g. load address, LateALU result). This block does not distinguish producer kinds.
- No handshake; the block updates every cycle. Stalled slots must present rd_we=0.

Optional Feature:
- Macro BYPASS_WB_FORWARD_EN.
- Defined: H2 exists and participates in selection as described above.
- Undefined:
  - H2 is not instantiated; selection is H1 then regfile.
  - The register file is then required to be write-first (read-after-write within the same edge).
  - Distance-2 dependencies return rs_val/rt_val.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, rs_val=0x11, rt_val=0x22 -> outputs 0x11/0x22. Then present rd_we=1, rd_index=3, rd_value=0x55 during reset -> still no forwarding after reset deasserts.
- Distance-1 forward: cycle t rd_we=1, rd_index=5, rd_value=0xDEADBEEF; cycle t+1 rs_index=5, rs_val=0 -> bypassed_rs_val=0xDEADBEEF. In the same cycle, rt_index=6, rt_val=0x7 -> 0x7.
- Distance-2 forward: write r7=0xA5A5A5A5 at t, rd_we=0 at t+1; t+2 rt_index=7, rt_val=0x1 -> 0xA5A5A5A5 with macro defined, 0x1 without.
- Priority: write r9=0x100 at t, r9=0x200 at t+1; t+2 rs_index=9 -> 0x200. At t+3 (H2 only, r9=0x200) -> 0x200.
- Zero register and write-disable: rd_we=1, rd_index=0, rd_value=0xFFFFFFFF -> next cycle rs_index=0, rs_val=0 gives 0. Separately, rd_we=0, rd_index=4, rd_value=0x99 -> next cycle rs_index=4, rs_val=0x3 gives 0x3.
- Both operands same register: write r12=0x1234 at t; t+1 rs_index=rt_index=12 -> both outputs 0x1234.
